// File: rtl/cozy_muldiv_pkg.sv
// Shared definitions for the cozy multiply/divide unit: op encodings,
// sequencer states and small op-decoding helpers used by the decoder too.
package cozy_muldiv_pkg;

    localparam logic [1:0] COZY_MD_MULL = 2'b00;
    localparam logic [1:0] COZY_MD_MULH = 2'b01;
    localparam logic [1:0] COZY_MD_DIVU = 2'b10;
    localparam logic [1:0] COZY_MD_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    // Upper op bit selects the divide datapath.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Lower op bit selects the high register half (MULH product / REMU remainder).
    function automatic logic md_take_high(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/cozy_muldiv_step.sv
// One iteration of the shared shift datapath.
// Multiply: {hi,lo} holds the partial product with the multiplier in lo;
//           add the multiplicand when lo[0] is set, then shift right.
// Divide:   hi is the partial remainder, lo the dividend/quotient;
//           shift one dividend bit in, trial-subtract, shift the quotient bit in.
module cozy_muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Compute both iteration flavours and pick one by the op bit.
    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        trial = {hi, lo[WIDTH-1]};
        fits  = (trial >= {1'b0, m});
        // When the trial fits the difference is below m, so WIDTH bits suffice.
        diff  = trial[WIDTH-1:0] - m;
        if (is_div) begin
            next_hi = fits ? diff : trial[WIDTH-1:0];
            next_lo = {lo[WIDTH-2:0], fits};
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/cozy_muldiv.sv
// Iterative unsigned multiply/divide unit for the cozy execute stage.
// Fixed latency of WIDTH+1 cycles from the accepting edge to the done cycle;
// the result is written back through wb_sel/wb_we for exactly one cycle.
module cozy_muldiv
    import cozy_muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] dst_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [SEL_W-1:0] wb_sel,
    output logic             wb_we
);

    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    cozy_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (md_is_div(op_q)),
        .hi      (hi_q),
        .lo      (lo_q),
        .m       (m_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sequencer, iteration counter, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= {CNT_W{1'b0}};
            op_q   <= 2'b00;
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            m_q    <= {WIDTH{1'b0}};
            busy   <= 1'b0;
            done   <= 1'b0;
            wb_we  <= 1'b0;
            result <= {WIDTH{1'b0}};
            wb_sel <= {SEL_W{1'b0}};
        end else begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Multiply keeps the multiplier in lo; divide keeps the dividend there.
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        cnt    <= {CNT_W{1'b0}};
                        op_q   <= op;
                        hi_q   <= {WIDTH{1'b0}};
                        lo_q   <= md_is_div(op) ? a : b;
                        m_q    <= md_is_div(op) ? b : a;
                        wb_sel <= dst_sel;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt == LAST) begin
                        // All iterations done; publish the selected half.
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        wb_we  <= 1'b1;
                        result <= md_take_high(op_q) ? hi_q : lo_q;
                    end else begin
                        hi_q <= step_hi;
                        lo_q <= step_lo;
                        cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cozy_muldiv.md
Name: cozy_muldiv

Overview:
Iterative 16-bit multiply/divide unit for the cozy CPU execute stage. It consumes the register file's read ports (rD_out, rS_out) as operands. It returns its result to the register file write port (rD_sel / rD_in / rD_we) through a one-cycle writeback strobe. Used for MUL/DIV instructions; the sequencer stalls while busy is high.

Parameters:
WIDTH, 16, operand/result width; iteration count equals WIDTH.
SEL_W, 4, register select width (16 registers).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
op  input  2  00 MULL (low product), 01 MULH (high product), 10 DIVU (quotient), 11 REMU (remainder), all unsigned.
a  input  WIDTH  operand A / dividend (from rD_out).
b  input  WIDTH  operand B / divisor (from rS_out).
dst_sel  input  SEL_W  destination register, latched with start.
busy  output  1  operation in progress.
done  output  1  one-cycle completion pulse.
result  output  WIDTH  result; holds last value until next done.
wb_sel  output  SEL_W  latched dst_sel, drives register file rD_sel during writeback.
wb_we  output  1  equals done; drives rD_we.

Behaviour:
- Reset (rst=1 at an edge): busy=0, done=0, wb_we=0, result=0, wb_sel=0, iteration counter=0, internal accumulators cleared. Reset has priority over everything, including mid-operation; an aborted op never produces done.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1, latch a, b, op, dst_sel at edge N and go to RUN.
  - RUN: one iteration per cycle for WIDTH cycles. busy=1 during cycles N+1..N+16.
  - DONE: entered at edge N+17. done=wb_we=1 and result valid during that cycle; busy=0.
  - DONE to IDLE, or directly to RUN if start=1 in the DONE cycle (back-to-back accepted).
- Latency: exactly WIDTH+1 = 17 cycles from start edge to done cycle, for every op including divide-by-zero.
- start while busy=1 is ignored; operands are not re-latched and no error is raised. Operand inputs may change freely after the start edge.
- Multiply: shift-add over a 2*WIDTH product register. MULL returns product[15:0], MULH returns product[31:16].
- Divide: restoring, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder. DIVU returns the quotient, REMU the remainder.
- Divide by zero (b=0): quotient 0xFFFF, remainder = a. These values fall out naturally from restoring division; no special-case timing.
- wb_we is asserted even when wb_sel=0; the register file discards R0 writes.
- result, wb_sel hold their values outside the done cycle.

Decomposition:
- Shared include cozy_defs.v: op encodings (COZY_MD_MULL/MULH/DIVU/REMU) and state encodings as localparams/defines, shared with the decoder.
- One natural sub-module: cozy_muldiv_step, combinational single iteration (add-or-skip for MUL, trial-subtract for DIV) selected by an op bit.
- FSM, counter and registers stay in cozy_muldiv.

Test Plan:
1. MULL a=0x1234 b=0x0010, dst_sel=3 -> done exactly 17 cycles after start, result=0x2340, wb_sel=3, wb_we=1 for one cycle; same operands with MULH -> 0x0001.
2. a=0xFFFF b=0xFFFF: MULL -> 0x0001, MULH -> 0xFFFE; busy high cycles 1..16 after start, low in the done cycle.
3. DIVU a=1000 b=7 -> 0x008E; REMU -> 0x0006. Divide-by-zero a=0x1234 b=0: DIVU -> 0xFFFF, REMU -> 0x1234, still 17-cycle latency.
4. Pulse start again with different operands at cycle 5 while busy -> ignored; the first op's result is unchanged. Assert start in the done cycle -> accepted, second done exactly 17 cycles later with correct result.
5. rst asserted at cycle 8 of an op -> next cycle busy=0, done=0, wb_we=0, result=0; no done pulse for 40 cycles. A new op afterwards completes correctly.
6. Run 200 random (op, a, b) pairs against a reference model -> all results match; done asserted for exactly one cycle each time.
